// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a melody by walking an external note table. Each entry supplies a
//   divider terminal count and a duration in units. The sequencer drives
//   MAXCOUNT to the clock divider for the note's duration. It inserts a muted
//   gap between notes and gates the speaker with MUTE. An entry with dur==0
//   marks end-of-song. Running past the last table entry also ends the song.
//
// Ports
//   CLK        system clock
//   RST        asynchronous, active-high reset
//   START      begin playback from entry 0 (only honoured in IDLE)
//   STOP       abort playback and return to IDLE (highest priority)
//   LOOP       restart from entry 0 at end-of-song instead of finishing
//   NOTE_ADDR  registered table address
//   NOTE_DATA  {maxcount[20:4], dur[3:0]} from a combinational ROM
//   MAXCOUNT   divider terminal count, 0 = rest
//   MUTE       1 = speaker silenced
//   PLAYING    1 while in FETCH/PLAY/GAP/END
//   DONE       one-cycle pulse on a non-looping end-of-song
module note_sequencer #(
  parameter int TICKS_PER_UNIT = 12_500_000,
  parameter int GAP_CYCLES     = 1_000_000,
  parameter int NUM_NOTES      = 16,
  parameter int AW             = $clog2(NUM_NOTES)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          STOP,
  input  logic          LOOP,
  output logic [AW-1:0] NOTE_ADDR,
  input  logic [20:0]   NOTE_DATA,
  output logic [16:0]   MAXCOUNT,
  output logic          MUTE,
  output logic          PLAYING,
  output logic          DONE
);

  localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLAY  = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   addr_d;
  logic [16:0]     maxcount_d;
  logic            mute_d;
  logic            done_d;
  logic            playing_d;
  logic [TW-1:0]   unit_cnt, unit_cnt_d;
  logic [3:0]      units_left, units_left_d;
  logic [GW-1:0]   gap_cnt, gap_cnt_d;

  logic [16:0]     note_max;
  logic [3:0]      note_dur;
  logic            unit_wrap;
  logic            gap_last;

  assign note_max  = NOTE_DATA[20:4];
  assign note_dur  = NOTE_DATA[3:0];
  assign unit_wrap = (unit_cnt == TW'(TICKS_PER_UNIT - 1));
  // With a gap of 0 or 1 cycles the first GAP cycle is also the last.
  assign gap_last  = (GAP_CYCLES <= 1) || (gap_cnt == GW'(GAP_CYCLES - 1));

  // Next-state and next-output logic; every register gets a hold default first.
  always_comb begin
    state_d      = state;
    addr_d       = NOTE_ADDR;
    maxcount_d   = MAXCOUNT;
    mute_d       = MUTE;
    done_d       = 1'b0;
    unit_cnt_d   = unit_cnt;
    units_left_d = units_left;
    gap_cnt_d    = gap_cnt;

    case (state)
      S_IDLE: begin
        addr_d     = '0;
        maxcount_d = 17'd0;
        mute_d     = 1'b1;
        if (START) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (note_dur == 4'd0) begin
          state_d = S_END;
        end else begin
          maxcount_d   = note_max;
          mute_d       = (note_max == 17'd0);
          unit_cnt_d   = '0;
          units_left_d = note_dur;
          state_d      = S_PLAY;
        end
      end
      S_PLAY: begin
        if (unit_wrap) begin
          unit_cnt_d = '0;
          if (units_left == 4'd1) begin
            // Note expired: silence and move on; the last table slot ends the song.
            mute_d = 1'b1;
            if (NOTE_ADDR == AW'(NUM_NOTES - 1)) begin
              state_d = S_END;
            end else begin
              addr_d = NOTE_ADDR + AW'(1);
              if (GAP_CYCLES == 0) begin
                state_d = S_FETCH;
              end else begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
              end
            end
          end else begin
            units_left_d = units_left - 4'd1;
          end
        end else begin
          unit_cnt_d = unit_cnt + TW'(1);
        end
      end
      S_GAP: begin
        mute_d = 1'b1;
        if (gap_last) begin
          state_d = S_FETCH;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      S_END: begin
        addr_d = '0;
        if (LOOP) begin
          state_d = S_FETCH;
        end else begin
          done_d     = 1'b1;
          maxcount_d = 17'd0;
          mute_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        addr_d     = '0;
        maxcount_d = 17'd0;
        mute_d     = 1'b1;
      end
    endcase

    // STOP overrides every other transition, including START and end-of-song.
    if (STOP) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      maxcount_d = 17'd0;
      mute_d     = 1'b1;
      done_d     = 1'b0;
    end else begin
      done_d = done_d;
    end

    playing_d = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Registered outputs and duration/gap counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      NOTE_ADDR  <= '0;
      MAXCOUNT   <= 17'd0;
      MUTE       <= 1'b1;
      PLAYING    <= 1'b0;
      DONE       <= 1'b0;
      unit_cnt   <= '0;
      units_left <= 4'd0;
      gap_cnt    <= '0;
    end else begin
      NOTE_ADDR  <= addr_d;
      MAXCOUNT   <= maxcount_d;
      MUTE       <= mute_d;
      PLAYING    <= playing_d;
      DONE       <= done_d;
      unit_cnt   <= unit_cnt_d;
      units_left <= units_left_d;
      gap_cnt    <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//   Directed bench for note_sequencer with TICKS_PER_UNIT=4, NUM_NOTES=4.
//   Instance dut uses GAP_CYCLES=2 and instance dut0 uses GAP_CYCLES=0.
//   Each has its own table ROM. Traces are indexed from t=0, the FETCH cycle
//   that follows the START edge.
module tb_note_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, stop, loop;
  logic [1:0]  addr;
  logic [20:0] data;
  logic [16:0] mc;
  logic        mute, playing, done;
  logic        start0, stop0, loop0;
  logic [1:0]  addr0;
  logic [20:0] data0;
  logic [16:0] mc0;
  logic        mute0, playing0, done0;

  logic [20:0] rom  [4];
  logic [20:0] rom0 [4];

  logic [16:0] tr_mc   [64];
  logic        tr_mute [64];
  logic        tr_play [64];
  logic        tr_done [64];
  logic [1:0]  tr_addr [64];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign data  = rom[addr];
  assign data0 = rom0[addr0];

  note_sequencer #(.TICKS_PER_UNIT(4), .GAP_CYCLES(2), .NUM_NOTES(4)) dut (
    .CLK(CLK), .RST(RST), .START(start), .STOP(stop), .LOOP(loop),
    .NOTE_ADDR(addr), .NOTE_DATA(data), .MAXCOUNT(mc), .MUTE(mute),
    .PLAYING(playing), .DONE(done)
  );

  note_sequencer #(.TICKS_PER_UNIT(4), .GAP_CYCLES(0), .NUM_NOTES(4)) dut0 (
    .CLK(CLK), .RST(RST), .START(start0), .STOP(stop0), .LOOP(loop0),
    .NOTE_ADDR(addr0), .NOTE_DATA(data0), .MAXCOUNT(mc0), .MUTE(mute0),
    .PLAYING(playing0), .DONE(done0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input int t, input bit sel);
    if (sel) begin
      tr_mc[t] = mc0; tr_mute[t] = mute0; tr_play[t] = playing0;
      tr_done[t] = done0; tr_addr[t] = addr0;
    end else begin
      tr_mc[t] = mc; tr_mute[t] = mute; tr_play[t] = playing;
      tr_done[t] = done; tr_addr[t] = addr;
    end
  endtask

  // Pulse START for one edge, then record n cycles starting at the FETCH cycle.
  task automatic capture(input int n, input bit sel);
    if (sel) start0 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start0 = 1'b0;
    sample(0, sel);
    for (int t = 1; t < n; t++) begin
      tick();
      sample(t, sel);
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic load_song1();
    rom[0] = {17'd47778, 4'd2};
    rom[1] = {17'd42566, 4'd1};
    rom[2] = {17'd0, 4'd0};
    rom[3] = {17'd5, 4'd1};
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    start0 = 1'b0; stop0 = 1'b0; loop0 = 1'b0;
    load_song1();
    for (int i = 0; i < 4; i++) rom0[i] = {17'(100 * (i + 1)), 4'd1};
    #12;
    checks++;
    if ({playing, mute, mc, addr, done} !== {1'b0, 1'b1, 17'd0, 2'd0, 1'b0}) begin
      $display("FAIL reset_dut: got play=%b mute=%b mc=%0d addr=%0d done=%b, want 0 1 0 0 0",
               playing, mute, mc, addr, done);
      errors++;
    end
    checks++;
    if ({playing0, mute0, mc0, addr0, done0} !== {1'b0, 1'b1, 17'd0, 2'd0, 1'b0}) begin
      $display("FAIL reset_dut0: got play=%b mute=%b mc=%0d addr=%0d done=%b, want 0 1 0 0 0",
               playing0, mute0, mc0, addr0, done0);
      errors++;
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_song();
    int c1, c2, cd;
    capture(24, 1'b0);
    c1 = 0; c2 = 0; cd = 0;
    for (int t = 0; t < 24; t++) begin
      if (tr_mc[t] == 17'd47778 && !tr_mute[t]) c1++;
      if (tr_mc[t] == 17'd42566 && !tr_mute[t]) c2++;
      if (tr_done[t]) cd++;
    end
    checks++;
    if ({tr_play[0], tr_mute[0], tr_mc[0]} !== {1'b1, 1'b1, 17'd0}) begin
      $display("FAIL song_fetch: got play=%b mute=%b mc=%0d, want 1 1 0", tr_play[0], tr_mute[0], tr_mc[0]);
      errors++;
    end
    checks++;
    if ({tr_mc[1], tr_mute[1]} !== {17'd47778, 1'b0}) begin
      $display("FAIL song_first_note: got mc=%0d mute=%b, want 47778 0", tr_mc[1], tr_mute[1]);
      errors++;
    end
    checks++;
    if (c1 !== 8) begin
      $display("FAIL song_note0_len: got %0d cycles, want 8", c1);
      errors++;
    end
    checks++;
    if ({tr_mute[9], tr_mute[10], tr_addr[9], tr_mc[9]} !== {1'b1, 1'b1, 2'd1, 17'd47778}) begin
      $display("FAIL song_gap: got mute=%b%b addr=%0d mc=%0d, want 11 1 47778",
               tr_mute[9], tr_mute[10], tr_addr[9], tr_mc[9]);
      errors++;
    end
    checks++;
    if (c2 !== 4 || tr_mc[12] !== 17'd42566) begin
      $display("FAIL song_note1: got %0d cycles mc12=%0d, want 4 42566", c2, tr_mc[12]);
      errors++;
    end
    checks++;
    if (cd !== 1 || tr_done[20] !== 1'b1) begin
      $display("FAIL song_done: got %0d pulses done20=%b, want 1 1", cd, tr_done[20]);
      errors++;
    end
    checks++;
    if ({tr_play[21], tr_mute[21], tr_mc[21], tr_addr[21]} !== {1'b0, 1'b1, 17'd0, 2'd0}) begin
      $display("FAIL song_idle: got play=%b mute=%b mc=%0d addr=%0d, want 0 1 0 0",
               tr_play[21], tr_mute[21], tr_mc[21], tr_addr[21]);
      errors++;
    end
  endtask

  task automatic test_loop();
    int c1, cd;
    loop = 1'b1;
    capture(30, 1'b0);
    c1 = 0; cd = 0;
    for (int t = 0; t < 30; t++) begin
      if (tr_mc[t] == 17'd47778 && !tr_mute[t]) c1++;
      if (tr_done[t]) cd++;
    end
    checks++;
    if ({tr_play[20], tr_addr[20], tr_mc[21], tr_mute[21]} !== {1'b1, 2'd0, 17'd47778, 1'b0}) begin
      $display("FAIL loop_restart: got play=%b addr=%0d mc=%0d mute=%b, want 1 0 47778 0",
               tr_play[20], tr_addr[20], tr_mc[21], tr_mute[21]);
      errors++;
    end
    checks++;
    if (cd !== 0 || c1 !== 16) begin
      $display("FAIL loop_replay: got done=%0d note0=%0d cycles, want 0 16", cd, c1);
      errors++;
    end
    loop = 1'b0;
    do_stop();
  endtask

  task automatic test_rest();
    int cr, cu;
    rom[0] = {17'd0, 4'd3};
    rom[1] = {17'd1000, 4'd1};
    rom[2] = {17'd0, 4'd0};
    capture(20, 1'b0);
    cr = 0; cu = 0;
    for (int t = 1; t <= 12; t++) if (tr_mute[t] && tr_mc[t] == 17'd0 && tr_addr[t] == 2'd0) cr++;
    for (int t = 0; t < 20; t++) if (!tr_mute[t]) cu++;
    checks++;
    if (cr !== 12 || cu !== 4) begin
      $display("FAIL rest_muted: got rest=%0d unmuted=%0d, want 12 4", cr, cu);
      errors++;
    end
    checks++;
    if ({tr_addr[13], tr_mute[13], tr_mc[16], tr_mute[16]} !== {2'd1, 1'b1, 17'd1000, 1'b0}) begin
      $display("FAIL rest_advance: got addr=%0d mute=%b mc=%0d mute16=%b, want 1 1 1000 0",
               tr_addr[13], tr_mute[13], tr_mc[16], tr_mute[16]);
      errors++;
    end
    do_stop();
    load_song1();
  endtask

  task automatic test_stop();
    int cd;
    capture(4, 1'b0);
    stop = 1'b1;
    tick();
    checks++;
    if ({playing, mute, mc, addr, done} !== {1'b0, 1'b1, 17'd0, 2'd0, 1'b0}) begin
      $display("FAIL stop_play: got play=%b mute=%b mc=%0d addr=%0d done=%b, want 0 1 0 0 0",
               playing, mute, mc, addr, done);
      errors++;
    end
    stop = 1'b0;
    cd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || playing) cd++;
    end
    checks++;
    if (cd !== 0) begin
      $display("FAIL stop_quiet: got %0d active cycles, want 0", cd);
      errors++;
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({playing, mute, mc} !== {1'b0, 1'b1, 17'd0}) begin
      $display("FAIL stop_start_same: got play=%b mute=%b mc=%0d, want 0 1 0", playing, mute, mc);
      errors++;
    end
    tick();
    checks++;
    if (playing !== 1'b0) begin
      $display("FAIL stop_start_idle: got play=%b, want 0", playing);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int cu;
    capture(24, 1'b1);
    cu = 0;
    for (int t = 0; t < 24; t++) if (!tr_mute[t]) cu++;
    checks++;
    if (cu !== 16 || tr_mc[1] !== 17'd100 || tr_mute[5] !== 1'b1) begin
      $display("FAIL b2b_len: got unmuted=%0d mc1=%0d mute5=%b, want 16 100 1", cu, tr_mc[1], tr_mute[5]);
      errors++;
    end
    checks++;
    if ({tr_mc[6], tr_mute[6], tr_mc[16], tr_addr[16]} !== {17'd200, 1'b0, 17'd400, 2'd3}) begin
      $display("FAIL b2b_notes: got mc6=%0d mute6=%b mc16=%0d addr16=%0d, want 200 0 400 3",
               tr_mc[6], tr_mute[6], tr_mc[16], tr_addr[16]);
      errors++;
    end
    checks++;
    if ({tr_play[20], tr_addr[20], tr_done[21], tr_play[21]} !== {1'b1, 2'd3, 1'b1, 1'b0}) begin
      $display("FAIL b2b_end: got play20=%b addr20=%0d done21=%b play21=%b, want 1 3 1 0",
               tr_play[20], tr_addr[20], tr_done[21], tr_play[21]);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    capture(10, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({playing, mute, mc, addr, done} !== {1'b0, 1'b1, 17'd0, 2'd0, 1'b0}) begin
      $display("FAIL async_rst: got play=%b mute=%b mc=%0d addr=%0d done=%b, want 0 1 0 0 0",
               playing, mute, mc, addr, done);
      errors++;
    end
    #2;
    RST = 1'b0;
    tick();
    capture(3, 1'b0);
    checks++;
    if ({tr_addr[0], tr_play[0], tr_mc[1], tr_mute[1], tr_addr[1]} !== {2'd0, 1'b1, 17'd47778, 1'b0, 2'd0}) begin
      $display("FAIL rst_replay: got addr=%0d play=%b mc=%0d mute=%b addr1=%0d, want 0 1 47778 0 0",
               tr_addr[0], tr_play[0], tr_mc[1], tr_mute[1], tr_addr[1]);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_song();
    test_loop();
    test_rest();
    test_stop();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
